// File: rtl/controle_varredura_servo_if.sv
// Handshake bundle between the sweep sequencer and the sonar top-level.
//   ligar           : sweep enable level (to sequencer)
//   medida_pronta   : measurement-done pulse (to sequencer)
//   largura         : servo position code for the PWM width select
//   solicita_medida : measurement request pulse
//   em_medida       : high while a measurement is outstanding
//   fim_varredura   : endpoint reached / direction reversed pulse
//   erro_timeout    : measurement timed out pulse
//   db_estado       : debug state code
// slave  = the sequencer side, master = the controller/bench side.
interface controle_varredura_servo_if;
  logic       ligar;
  logic       medida_pronta;
  logic [1:0] largura;
  logic       solicita_medida;
  logic       em_medida;
  logic       fim_varredura;
  logic       erro_timeout;
  logic [2:0] db_estado;

  modport slave (
    input  ligar, medida_pronta,
    output largura, solicita_medida, em_medida, fim_varredura, erro_timeout, db_estado
  );

  modport master (
    output ligar, medida_pronta,
    input  largura, solicita_medida, em_medida, fim_varredura, erro_timeout, db_estado
  );
endinterface

// File: rtl/controle_varredura_servo.sv
// Servo sweep sequencer. Steps the sonar servo back and forth between
// POS_MIN and POS_MAX; at each position it settles for T_ASSENTA cycles,
// requests one measurement, waits for medida_pronta (or T_TIMEOUT cycles),
// then advances one position.
// Ports:
//   clock : system clock
//   reset : asynchronous active-low reset
//   bus   : handshake bundle (slave side), see controle_varredura_servo_if
// All outputs are registered.
module controle_varredura_servo #(
  parameter int T_ASSENTA = 25000000,
  parameter int T_TIMEOUT = 5000000,
  parameter int POS_MIN   = 0,
  parameter int POS_MAX   = 3
) (
  input logic                         clock,
  input logic                         reset,
  controle_varredura_servo_if.slave   bus
);

  localparam logic [2:0] OCIOSO  = 3'd0;
  localparam logic [2:0] ASSENTA = 3'd1;
  localparam logic [2:0] MEDE    = 3'd2;
  localparam logic [2:0] AVANCA  = 3'd3;

  localparam logic [31:0] ASS_FIM = 32'(T_ASSENTA - 1);
  localparam logic [31:0] TO_FIM  = 32'(T_TIMEOUT - 1);
  localparam logic [1:0]  PMIN    = 2'(POS_MIN);
  localparam logic [1:0]  PMAX    = 2'(POS_MAX);

  logic [2:0]  estado_q, estado_d;
  logic [31:0] cnt_ass_q, cnt_ass_d;
  logic [31:0] cnt_to_q, cnt_to_d;
  logic [1:0]  largura_q, largura_d;
  logic        desce_q, desce_d;     // 1 = sweeping towards POS_MIN
  logic        sol_q, sol_d;
  logic        em_q, em_d;
  logic        fim_q, fim_d;
  logic        erro_q, erro_d;

  always_comb begin
    estado_d  = estado_q;
    cnt_ass_d = cnt_ass_q;
    cnt_to_d  = cnt_to_q;
    largura_d = largura_q;
    desce_d   = desce_q;
    sol_d     = 1'b0;
    em_d      = 1'b0;
    fim_d     = 1'b0;
    erro_d    = 1'b0;
    case (estado_q)
      OCIOSO: begin
        if (bus.ligar) begin
          estado_d  = ASSENTA;
          cnt_ass_d = '0;
        end
      end
      ASSENTA: begin
        if (!bus.ligar) begin
          estado_d  = OCIOSO;
          cnt_ass_d = '0;
        end else if (cnt_ass_q == ASS_FIM) begin
          // outputs are registered, so the request/busy flags are raised
          // on the same edge that enters MEDE
          estado_d  = MEDE;
          cnt_ass_d = '0;
          cnt_to_d  = '0;
          sol_d     = 1'b1;
          em_d      = 1'b1;
        end else begin
          cnt_ass_d = cnt_ass_q + 32'd1;
        end
      end
      MEDE: begin
        // ligar is deliberately ignored: a started measurement always completes.
        // pronta is tested first so it wins over a coincident final count.
        if (bus.medida_pronta) begin
          estado_d = AVANCA;
          cnt_to_d = '0;
        end else if (cnt_to_q == TO_FIM) begin
          estado_d = AVANCA;
          cnt_to_d = '0;
          erro_d   = 1'b1;
        end else begin
          cnt_to_d = cnt_to_q + 32'd1;
          em_d     = 1'b1;
        end
      end
      AVANCA: begin
        if (PMIN == PMAX) begin
          fim_d = 1'b1;
        end else if (!desce_q) begin
          if (largura_q < PMAX) begin
            largura_d = largura_q + 2'd1;
          end else begin
            desce_d   = 1'b1;
            largura_d = largura_q - 2'd1;
            fim_d     = 1'b1;
          end
        end else begin
          if (largura_q > PMIN) begin
            largura_d = largura_q - 2'd1;
          end else begin
            desce_d   = 1'b0;
            largura_d = largura_q + 2'd1;
            fim_d     = 1'b1;
          end
        end
        estado_d  = bus.ligar ? ASSENTA : OCIOSO;
        cnt_ass_d = '0;
      end
      default: estado_d = OCIOSO;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q  <= OCIOSO;
      cnt_ass_q <= '0;
      cnt_to_q  <= '0;
      largura_q <= PMIN;
      desce_q   <= 1'b0;
      sol_q     <= 1'b0;
      em_q      <= 1'b0;
      fim_q     <= 1'b0;
      erro_q    <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      cnt_ass_q <= cnt_ass_d;
      cnt_to_q  <= cnt_to_d;
      largura_q <= largura_d;
      desce_q   <= desce_d;
      sol_q     <= sol_d;
      em_q      <= em_d;
      fim_q     <= fim_d;
      erro_q    <= erro_d;
    end
  end

  assign bus.largura         = largura_q;
  assign bus.solicita_medida = sol_q;
  assign bus.em_medida       = em_q;
  assign bus.fim_varredura   = fim_q;
  assign bus.erro_timeout    = erro_q;
  assign bus.db_estado       = estado_q;

endmodule

// File: tb/tb_controle_varredura_servo.sv
module tb_controle_varredura_servo;
  localparam int T_A  = 10;
  localparam int T_T  = 20;
  localparam int PMIN = 0;
  localparam int PMAX = 3;
  localparam int N    = PMAX - PMIN;

  logic clock;
  logic reset;
  int   n_chk, n_pass;

  controle_varredura_servo_if bus_if();

  controle_varredura_servo #(.T_ASSENTA(T_A), .T_TIMEOUT(T_T), .POS_MIN(PMIN), .POS_MAX(PMAX))
    dut (.clock(clock), .reset(reset), .bus(bus_if));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // The sweep is a sequence of moves numbered k = 0,1,2,...; after k moves the
  // servo sits at the k-th point of a triangle wave of period 2N, and a move
  // starting at a multiple of N (other than the very first) is a reversal.
  function automatic int pos_of(input int k);
    int p;
    if (N == 0) return PMIN;
    p = k % (2 * N);
    return PMIN + ((p <= N) ? p : (2 * N - p));
  endfunction

  localparam int IDLE = 0, SETTLE = 1, MEAS = 2, ADV = 3;
  int   m_ph, m_left, m_idx;
  logic e_sol, e_em, e_fim, e_erro;

  always @(posedge clock or negedge reset) begin : mdl
    int ph, left, idx;
    logic sol, em, fim, erro;
    if (!reset) begin
      m_ph <= IDLE; m_left <= 0; m_idx <= 0;
      e_sol <= 1'b0; e_em <= 1'b0; e_fim <= 1'b0; e_erro <= 1'b0;
    end else begin
      ph = m_ph; left = m_left; idx = m_idx;
      sol = 1'b0; em = 1'b0; fim = 1'b0; erro = 1'b0;
      case (ph)
        IDLE:   if (bus_if.ligar) begin ph = SETTLE; left = T_A; end
        SETTLE: if (!bus_if.ligar) ph = IDLE;
                else begin
                  left = left - 1;
                  if (left == 0) begin ph = MEAS; left = T_T; sol = 1'b1; em = 1'b1; end
                end
        MEAS:   if (bus_if.medida_pronta) ph = ADV;
                else begin
                  left = left - 1;
                  if (left == 0) begin ph = ADV; erro = 1'b1; end
                  else em = 1'b1;
                end
        default: begin
          fim  = (N == 0) || ((idx % N == 0) && idx > 0);
          idx  = idx + 1;
          ph   = bus_if.ligar ? SETTLE : IDLE;
          left = T_A;
        end
      endcase
      m_ph <= ph; m_left <= left; m_idx <= idx;
      e_sol <= sol; e_em <= em; e_fim <= fim; e_erro <= erro;
    end
  end

  // per-cycle compare of every output against the model
  always @(negedge clock) begin
    if (reset)
      chk("cycle", {23'd0, bus_if.largura, bus_if.solicita_medida, bus_if.em_medida,
                    bus_if.fim_varredura, bus_if.erro_timeout, bus_if.db_estado},
                   {23'd0, 2'(pos_of(m_idx)), e_sol, e_em, e_fim, e_erro, 3'(m_ph)});
  end

  // ---------------- measurement responder ----------------
  logic resp_on, resp_rand, pend;
  int   resp_dly, pcnt, noise;

  always @(negedge clock) begin : resp
    logic p;
    p = 1'b0;
    if (!reset) pend = 1'b0;
    else if (bus_if.solicita_medida && resp_on) begin
      pend = 1'b1;
      pcnt = resp_rand ? int'($urandom_range(0, 25)) : resp_dly;
    end
    if (pend) begin
      if (pcnt == 0) begin p = 1'b1; pend = 1'b0; end
      else pcnt = pcnt - 1;
    end
    if (noise == 1 && bus_if.db_estado == 3'd1 && ($urandom % 3) == 0) p = 1'b1;
    if (noise == 2 && ($urandom % 10) == 0) p = 1'b1;
    bus_if.medida_pronta = p;
  end

  // position recorder for the sweep-order checks
  logic rec;
  int   solq[$], fimq[$];
  always @(negedge clock) begin
    if (reset && rec) begin
      if (bus_if.solicita_medida) solq.push_back(int'(bus_if.largura));
      if (bus_if.fim_varredura)   fimq.push_back(int'(bus_if.largura));
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clock);
  endtask

  task automatic wait_sol(output int cyc);
    cyc = 0;
    do begin @(negedge clock); cyc++; end
    while (!bus_if.solicita_medida && cyc < 300);
    if (!bus_if.solicita_medida) chk("wait_solicita", 0, 1);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0; bus_if.ligar = 1'b0;
    tick(2);
    reset = 1'b1;
  endtask

  initial begin
    int cyc, cnt;
    int exp1[8];
    exp1 = '{0, 1, 2, 3, 2, 1, 0, 1};
    n_chk = 0; n_pass = 0;
    reset = 1'b0; bus_if.ligar = 1'b0;
    resp_on = 1'b1; resp_rand = 1'b0; resp_dly = 3; noise = 0; rec = 1'b0;
    pend = 1'b0; pcnt = 0;
    tick(2);
    chk("reset_outputs", {bus_if.largura, bus_if.solicita_medida, bus_if.em_medida,
                          bus_if.fim_varredura, bus_if.erro_timeout, bus_if.db_estado}, 0);
    reset = 1'b1;

    // 1: normal sweep, pronta 3 cycles after each request
    tick(1);
    rec = 1'b1;
    bus_if.ligar = 1'b1;
    wait_sol(cyc);
    chk("latency_ligar_to_sol", cyc, 11);
    cnt = 0;
    while (solq.size() < 8 && cnt < 2000) begin tick(1); cnt++; end
    rec = 1'b0;
    chk("sweep_count", solq.size(), 8);
    for (int i = 0; i < 8 && i < solq.size(); i++) chk("sweep_pos", solq[i], exp1[i]);
    chk("fim_count", fimq.size(), 2);
    if (fimq.size() == 2) begin
      chk("fim_at_3to2", fimq[0], 2);
      chk("fim_at_0to1", fimq[1], 1);
    end

    // 2: no answers -> timeouts
    do_reset();
    resp_on = 1'b0;
    bus_if.ligar = 1'b1;
    wait_sol(cyc);
    cnt = 0;
    while (bus_if.em_medida && cnt < 100) begin cnt++; tick(1); end
    chk("em_cycles_timeout", cnt, T_T);
    chk("erro_pulse", bus_if.erro_timeout, 1);
    tick(1);
    chk("erro_one_cycle", bus_if.erro_timeout, 0);
    wait_sol(cyc);
    chk("advance_after_timeout", bus_if.largura, 1);

    // 3: drop ligar mid-settle at position 2
    do_reset();
    resp_on = 1'b1; resp_dly = 3;
    bus_if.ligar = 1'b1;
    cnt = 0;
    while (!(bus_if.largura == 2'd2 && bus_if.db_estado == 3'd1) && cnt < 300) begin tick(1); cnt++; end
    tick(3);
    bus_if.ligar = 1'b0;
    tick(1);
    chk("idle_after_drop", bus_if.db_estado, 0);
    chk("largura_held", bus_if.largura, 2);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin tick(1); if (bus_if.solicita_medida) cnt++; end
    chk("no_sol_when_idle", cnt, 0);
    resp_dly = 5;
    bus_if.ligar = 1'b1;
    wait_sol(cyc);
    chk("resettle_latency", cyc, 11);
    chk("resettle_pos", bus_if.largura, 2);

    // 4: drop ligar during the measurement; pronta arrives 5 cycles later
    bus_if.ligar = 1'b0;
    cnt = 0;
    do begin tick(1); cnt++; end while (bus_if.db_estado != 3'd0 && cnt < 60);
    chk("mede_completes_pos", bus_if.largura, 3);
    tick(3);
    chk("em_low_idle", {bus_if.em_medida, bus_if.db_estado}, 0);

    // 5: reset in the middle of a measurement at position 3
    resp_dly = 3;
    bus_if.ligar = 1'b1;
    wait_sol(cyc);
    chk("pos_before_reset", bus_if.largura, 3);
    #2 reset = 1'b0;
    #1 chk("async_reset", {bus_if.largura, bus_if.em_medida, bus_if.db_estado}, 0);
    @(negedge clock);
    reset = 1'b1;
    wait_sol(cyc);
    chk("restart_pos0", bus_if.largura, 0);
    wait_sol(cyc);
    chk("restart_pos1", bus_if.largura, 1);

    // 6: pronta together with solicita; noise pulses during settle
    resp_dly = 0; noise = 1;
    wait_sol(cyc);
    tick(1);
    chk("same_cycle_pronta_avanca", bus_if.db_estado, 3);
    tick(1);
    cnt = 0;
    while (bus_if.db_estado == 3'd1 && cnt < 50) begin cnt++; tick(1); end
    chk("settle_ignores_pronta", cnt, T_A);
    noise = 0;

    // random soak against the model
    do_reset();
    resp_rand = 1'b1; noise = 2;
    bus_if.ligar = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      tick(1);
      if (($urandom % 200) == 0) bus_if.ligar = ~bus_if.ligar;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
